branch_predictor_btb: RTL and testbench

BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

---
 rtl/branch_predictor_btb_if.sv | 32 +++
 rtl/branch_predictor_btb.sv | 110 +++++++++++
 tb/tb_branch_predictor_btb.sv | 117 +++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// rtl/branch_predictor_btb_if.sv - fetch lookup / stage-4 resolve / statistics bundle
// The master drives the fetch PC and resolved branches; the slave answers with predictions.
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
);
  logic [ADDR_W-1:0] s1_pc;
  logic              s1_hit;
  logic              s1_pred;
  logic [ADDR_W-1:0] s1_target;
  logic              s4_branch;
  logic [ADDR_W-1:0] s4_pc;
  logic [ADDR_W-1:0] s4_target;
  logic              s4_taken;
  logic              s4_hit;
  logic              s4_pred;
  logic [1:0]        mux_signal;
  logic              flush;
  logic [STAT_W-1:0] p_acerto;
  logic [STAT_W-1:0] p_erro;
  logic [STAT_W-1:0] p_cold;

  modport slave (
    input  s1_pc, s4_branch, s4_pc, s4_target, s4_taken, s4_hit, s4_pred,
    output s1_hit, s1_pred, s1_target, mux_signal, flush, p_acerto, p_erro, p_cold
  );

  modport master (
    output s1_pc, s4_branch, s4_pc, s4_target, s4_taken, s4_hit, s4_pred,
    input  s1_hit, s1_pred, s1_target, mux_signal, flush, p_acerto, p_erro, p_cold
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped branch target buffer with saturating counters
// Combinational stage-1 lookup, stage-4 update on resolution, and prediction statistics.
module branch_predictor_btb #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_predictor_btb_if.slave bp
);
  localparam int DEPTH = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK_N = CTR_WEAK_T - CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX    = '1;
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;

  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag    [DEPTH];
  logic [ADDR_W-1:0] r_target [DEPTH];
  logic [CTR_W-1:0]  r_ctr    [DEPTH];
  logic [STAT_W-1:0] r_acerto;
  logic [STAT_W-1:0] r_erro;
  logic [STAT_W-1:0] r_cold;

  logic [INDEX_W-1:0] w_idx1;
  logic [TAG_W-1:0]   w_tag1;
  logic               w_hit1;
  logic [INDEX_W-1:0] w_idx4;
  logic [TAG_W-1:0]   w_tag4;
  logic               w_hit4;
  logic               w_mispredict;
  logic [CTR_W-1:0]   w_ctr_next;
  logic [1:0]         w_mux;

  assign w_idx1 = bp.s1_pc[INDEX_W+1:2];
  assign w_tag1 = bp.s1_pc[ADDR_W-1:INDEX_W+2];
  assign w_hit1 = r_valid[w_idx1] && (r_tag[w_idx1] == w_tag1);

  assign bp.s1_hit    = w_hit1;
  assign bp.s1_pred   = w_hit1 & r_ctr[w_idx1][CTR_W-1];
  assign bp.s1_target = w_hit1 ? r_target[w_idx1] : '0;

  // Update-side hit uses the live table, not the pipelined s4_hit flag.
  assign w_idx4 = bp.s4_pc[INDEX_W+1:2];
  assign w_tag4 = bp.s4_pc[ADDR_W-1:INDEX_W+2];
  assign w_hit4 = r_valid[w_idx4] && (r_tag[w_idx4] == w_tag4);

  assign w_mispredict = bp.s4_branch &
                        ((~bp.s4_hit & bp.s4_taken) | (bp.s4_hit & (bp.s4_pred != bp.s4_taken)));

  always_comb begin
    w_mux = 2'd0;
    if (w_mispredict && bp.s4_taken)       w_mux = 2'd3;
    else if (w_mispredict)                 w_mux = 2'd2;
    else if (w_hit1 && r_ctr[w_idx1][CTR_W-1]) w_mux = 2'd1;
  end

  assign bp.mux_signal = w_mux;
  assign bp.flush      = w_mispredict;

  always_comb begin
    w_ctr_next = r_ctr[w_idx4];
    if (!w_hit4)
      w_ctr_next = bp.s4_taken ? CTR_WEAK_T : CTR_WEAK_N;
    else if (bp.s4_taken && r_ctr[w_idx4] != CTR_MAX)
      w_ctr_next = r_ctr[w_idx4] + CTR_W'(1);
    else if (!bp.s4_taken && r_ctr[w_idx4] != '0)
      w_ctr_next = r_ctr[w_idx4] - CTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_WEAK_N;
    end else if (bp.s4_branch) begin
      r_valid[w_idx4] <= 1'b1;
      r_ctr[w_idx4]   <= w_ctr_next;
    end
  end

  // Tag/target carry no reset; r_valid alone gates every hit.
  always_ff @(posedge clk) begin
    if (!rst && bp.s4_branch) begin
      if (!w_hit4) r_tag[w_idx4] <= w_tag4;
      if (!w_hit4 || bp.s4_taken) r_target[w_idx4] <= bp.s4_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acerto <= '0;
      r_erro   <= '0;
      r_cold   <= '0;
    end else if (bp.s4_branch) begin
      if (bp.s4_hit && (bp.s4_pred == bp.s4_taken) && r_acerto != STAT_MAX)
        r_acerto <= r_acerto + STAT_W'(1);
      if (bp.s4_hit && (bp.s4_pred != bp.s4_taken) && r_erro != STAT_MAX)
        r_erro <= r_erro + STAT_W'(1);
      if (!bp.s4_hit && bp.s4_taken && r_cold != STAT_MAX)
        r_cold <= r_cold + STAT_W'(1);
    end
  end

  assign bp.p_acerto = r_acerto;
  assign bp.p_erro   = r_erro;
  assign bp.p_cold   = r_cold;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - scoreboard bench for branch_predictor_btb
// Directed vectors push expected outputs; a negedge monitor pops and compares.
module tb_branch_predictor_btb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_btb_if #(.ADDR_W(32), .STAT_W(32)) bif ();

  branch_predictor_btb #(.ADDR_W(32), .INDEX_W(4), .CTR_W(2), .STAT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bif.slave)
  );

  typedef struct {
    string       name;
    logic        hit;
    logic        pred;
    logic [31:0] tgt;
    logic [1:0]  mux;
    logic        flush;
    logic [31:0] acc;
    logic [31:0] err;
    logic [31:0] cold;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input string f, input logic [31:0] a, input logic [31:0] e);
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, f, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      chk(e.name, "s1_hit",     {31'd0, bif.s1_hit},     {31'd0, e.hit});
      chk(e.name, "s1_pred",    {31'd0, bif.s1_pred},    {31'd0, e.pred});
      chk(e.name, "s1_target",  bif.s1_target,           e.tgt);
      chk(e.name, "mux_signal", {30'd0, bif.mux_signal}, {30'd0, e.mux});
      chk(e.name, "flush",      {31'd0, bif.flush},      {31'd0, e.flush});
      chk(e.name, "p_acerto",   bif.p_acerto,            e.acc);
      chk(e.name, "p_erro",     bif.p_erro,              e.err);
      chk(e.name, "p_cold",     bif.p_cold,              e.cold);
    end
  end

  task automatic vec(input string nm, input logic r, input logic [31:0] s1pc,
                     input logic br, input logic [31:0] s4pc, input logic [31:0] s4tgt,
                     input logic tk, input logic h4, input logic p4,
                     input logic e_hit, input logic e_pred, input logic [31:0] e_tgt,
                     input logic [1:0] e_mux, input logic e_flush,
                     input logic [31:0] e_acc, input logic [31:0] e_err, input logic [31:0] e_cold);
    exp_t e;
    rst           = r;
    bif.s1_pc     = s1pc;
    bif.s4_branch = br;
    bif.s4_pc     = s4pc;
    bif.s4_target = s4tgt;
    bif.s4_taken  = tk;
    bif.s4_hit    = h4;
    bif.s4_pred   = p4;
    e.name = nm; e.hit = e_hit; e.pred = e_pred; e.tgt = e_tgt; e.mux = e_mux;
    e.flush = e_flush; e.acc = e_acc; e.err = e_err; e.cold = e_cold;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bif.s1_pc = '0; bif.s4_branch = 1'b0; bif.s4_pc = '0; bif.s4_target = '0;
    bif.s4_taken = 1'b0; bif.s4_hit = 1'b0; bif.s4_pred = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //   name          rst s1_pc      br s4_pc      s4_tgt     tk h4 p4  hit pred tgt       mux  fl acc err cold
    vec("reset_look",  0, 32'h40,   0, 32'h0,   32'h0,   0, 0, 0,  0, 0, 32'h0,   2'd0, 0, 0, 0, 0);
    vec("cold_alloc",  0, 32'h40,   1, 32'h40,  32'h100, 1, 0, 0,  0, 0, 32'h0,   2'd3, 1, 0, 0, 0);
    vec("hit_after",   0, 32'h40,   0, 32'h0,   32'h0,   0, 0, 0,  1, 1, 32'h100, 2'd1, 0, 0, 0, 1);
    vec("nt_mispred",  0, 32'h40,   1, 32'h40,  32'h0,   0, 1, 1,  1, 1, 32'h100, 2'd2, 1, 0, 0, 1);
    vec("nt_correct",  0, 32'h40,   1, 32'h40,  32'h0,   0, 1, 0,  1, 0, 32'h100, 2'd0, 0, 0, 1, 1);
    vec("ctr_zero",    0, 32'h40,   0, 32'h0,   32'h0,   0, 0, 0,  1, 0, 32'h100, 2'd0, 0, 1, 1, 1);
    vec("tk_from0",    0, 32'h40,   1, 32'h40,  32'h100, 1, 1, 0,  1, 0, 32'h100, 2'd3, 1, 1, 1, 1);
    vec("ctr_one",     0, 32'h40,   0, 32'h0,   32'h0,   0, 0, 0,  1, 0, 32'h100, 2'd0, 0, 1, 2, 1);
    vec("tk_1to2",     0, 32'h44,   1, 32'h40,  32'h100, 1, 1, 0,  0, 0, 32'h0,   2'd3, 1, 1, 2, 1);
    vec("tk_2to3",     0, 32'h44,   1, 32'h40,  32'h100, 1, 1, 1,  0, 0, 32'h0,   2'd0, 0, 1, 3, 1);
    vec("tk_sat_a",    0, 32'h44,   1, 32'h40,  32'h100, 1, 1, 1,  0, 0, 32'h0,   2'd0, 0, 2, 3, 1);
    vec("tk_sat_b",    0, 32'h44,   1, 32'h40,  32'h200, 1, 1, 1,  0, 0, 32'h0,   2'd0, 0, 3, 3, 1);
    vec("nt_from3",    0, 32'h44,   1, 32'h40,  32'h300, 0, 1, 1,  0, 0, 32'h0,   2'd2, 1, 4, 3, 1);
    vec("sat_check",   0, 32'h40,   0, 32'h0,   32'h0,   0, 0, 0,  1, 1, 32'h200, 2'd1, 0, 4, 4, 1);
    vec("alias_alloc", 0, 32'h440,  1, 32'h440, 32'h500, 1, 0, 0,  0, 0, 32'h0,   2'd3, 1, 4, 4, 1);
    vec("alias_old",   0, 32'h40,   0, 32'h0,   32'h0,   0, 0, 0,  0, 0, 32'h0,   2'd0, 0, 4, 4, 2);
    vec("alias_new",   0, 32'h440,  0, 32'h0,   32'h0,   0, 0, 0,  1, 1, 32'h500, 2'd1, 0, 4, 4, 2);
    vec("same_cyc_upd",0, 32'h440,  1, 32'h440, 32'h0,   0, 1, 1,  1, 1, 32'h500, 2'd2, 1, 4, 4, 2);
    vec("same_cyc_nxt",0, 32'h440,  0, 32'h0,   32'h0,   0, 0, 0,  1, 0, 32'h500, 2'd0, 0, 4, 5, 2);
    vec("same_cyc_new",0, 32'h48,   1, 32'h48,  32'h600, 1, 0, 0,  0, 0, 32'h0,   2'd3, 1, 4, 5, 2);
    vec("new_visible", 0, 32'h48,   0, 32'h0,   32'h0,   0, 0, 0,  1, 1, 32'h600, 2'd1, 0, 4, 5, 3);
    vec("rst_w_branch",1, 32'h48,   1, 32'h4C,  32'h700, 1, 0, 0,  1, 1, 32'h600, 2'd3, 1, 4, 5, 3);
    vec("post_rst_4c", 0, 32'h4C,   0, 32'h0,   32'h0,   0, 0, 0,  0, 0, 32'h0,   2'd0, 0, 0, 0, 0);
    vec("post_rst_48", 0, 32'h48,   0, 32'h0,   32'h0,   0, 0, 0,  0, 0, 32'h0,   2'd0, 0, 0, 0, 0);
    vec("post_rst_440",0, 32'h440,  0, 32'h0,   32'h0,   0, 0, 0,  0, 0, 32'h0,   2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
